// File: rtl/wr_ctrl_if.sv
// Start/stop control, show-ahead FIFO read side and Avalon-MM burst write bus for wr_ctrl.
interface wr_ctrl_if #(
  parameter int unsigned BURST_W = 16,
  parameter int unsigned USEDW_W = 9
);
  logic               wr_ctrl;
  logic               flush;
  logic [31:0]        buf_begin;
  logic [31:0]        buf_end;
  logic               wr_ctrl_rdy;
  logic               wr_done;
  logic [31:0]        words_written;
  logic [31:0]        fifo_q;
  logic               empty;
  logic [USEDW_W-1:0] usedw;
  logic               rdreq;
  logic [31:0]        address;
  logic [31:0]        writedata;
  logic               write;
  logic [BURST_W-1:0] burstcount;
  logic               waitrequest;

  modport master (
    input  wr_ctrl, flush, buf_begin, buf_end, fifo_q, empty, usedw, waitrequest,
    output wr_ctrl_rdy, wr_done, words_written, rdreq, address, writedata, write, burstcount
  );

  modport slave (
    output wr_ctrl, flush, buf_begin, buf_end, fifo_q, empty, usedw, waitrequest,
    input  wr_ctrl_rdy, wr_done, words_written, rdreq, address, writedata, write, burstcount
  );
endinterface

// File: rtl/wr_ctrl.sv
// Avalon-MM burst write master: drains a show-ahead FIFO into [buf_begin, buf_end),
// starting a burst only once the FIFO already holds every word of it.
module wr_ctrl #(
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned BURST_W   = 16,
  parameter int unsigned USEDW_W   = 9
) (
  input  logic      clk,
  input  logic      reset,
  wr_ctrl_if.master bus
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_DATA = 2'd1;
  localparam logic [1:0] S_BURST     = 2'd2;
  localparam logic [1:0] S_DONE      = 2'd3;

  localparam logic [31:0]        MAX_BURST_C = 32'(MAX_BURST);
  localparam logic [BURST_W-1:0] ONE_B       = BURST_W'(1);

  logic [1:0]         state_q, state_d;
  logic [31:0]        cur_addr_q, cur_addr_d;
  logic [31:0]        remaining_q, remaining_d;
  logic [31:0]        words_written_q, words_written_d;
  logic [31:0]        address_q, address_d;
  logic [BURST_W-1:0] burstcount_q, burstcount_d;
  logic [BURST_W-1:0] beat_q, beat_d;
  logic               write_q, write_d;
  logic               rdy_q, rdy_d;
  logic               done_q, done_d;

  logic [USEDW_W-1:0] usedw;
  logic [31:0]        usedw_c;
  logic [31:0]        region_words_c;
  logic [31:0]        blen_c;
  logic               accept_c;
  logic               last_beat_c;

  // Region size in words; an empty or inverted region yields zero
  always_comb begin
    usedw          = bus.usedw;
    usedw_c        = 32'(usedw);
    region_words_c = (bus.buf_end > bus.buf_begin) ? ((bus.buf_end - bus.buf_begin) >> 2) : 32'd0;
    blen_c         = (remaining_q < MAX_BURST_C) ? remaining_q : MAX_BURST_C;
    accept_c       = write_q & ~bus.waitrequest;
    last_beat_c    = (beat_q == (burstcount_q - ONE_B));
  end

  always_comb begin
    state_d         = state_q;
    cur_addr_d      = cur_addr_q;
    remaining_d     = remaining_q;
    words_written_d = words_written_q;
    address_d       = address_q;
    burstcount_d    = burstcount_q;
    beat_d          = beat_q;
    write_d         = write_q;
    rdy_d           = rdy_q;
    done_d          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.wr_ctrl) begin
          cur_addr_d      = bus.buf_begin & ~32'd3;
          remaining_d     = region_words_c;
          words_written_d = 32'd0;
          rdy_d           = 1'b0;
          state_d         = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        // flush is only honoured between bursts, never inside one
        if ((remaining_q == 32'd0) || bus.flush) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (usedw_c >= blen_c) begin
          address_d    = cur_addr_q;
          burstcount_d = BURST_W'(blen_c);
          beat_d       = '0;
          write_d      = 1'b1;
          state_d      = S_BURST;
        end
      end
      S_BURST: begin
        if (accept_c) begin
          beat_d          = beat_q + ONE_B;
          words_written_d = words_written_q + 32'd1;
          if (last_beat_c) begin
            write_d     = 1'b0;
            cur_addr_d  = cur_addr_q + (32'(burstcount_q) << 2);
            remaining_d = remaining_q - 32'(burstcount_q);
            state_d     = S_WAIT_DATA;
          end
        end
      end
      default: begin
        rdy_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cur_addr_q      <= '0;
      remaining_q     <= '0;
      words_written_q <= '0;
      address_q       <= '0;
      burstcount_q    <= '0;
      beat_q          <= '0;
      write_q         <= 1'b0;
      rdy_q           <= 1'b1;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cur_addr_q      <= cur_addr_d;
      remaining_q     <= remaining_d;
      words_written_q <= words_written_d;
      address_q       <= address_d;
      burstcount_q    <= burstcount_d;
      beat_q          <= beat_d;
      write_q         <= write_d;
      rdy_q           <= rdy_d;
      done_q          <= done_d;
    end
  end

  // Data and pop follow the FIFO head and the slave stall directly
  assign bus.rdreq         = accept_c;
  assign bus.writedata     = bus.fifo_q;
  assign bus.address       = address_q;
  assign bus.burstcount    = burstcount_q;
  assign bus.write         = write_q;
  assign bus.wr_ctrl_rdy   = rdy_q;
  assign bus.wr_done       = done_q;
  assign bus.words_written = words_written_q;

  rdreq_not_empty: assert property (@(posedge clk) disable iff (reset) !(accept_c && bus.empty))
    else $error("wr_ctrl: rdreq asserted while FIFO empty");

endmodule

// File: tb/tb_wr_ctrl.sv
// Scoreboard bench for wr_ctrl: directed runs push expected beats/completions, a monitor checks them.
module tb_wr_ctrl;

  localparam int MB = 4;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] bc;
    logic [31:0] data;
  } beat_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wr_ctrl_if #(.BURST_W(16), .USEDW_W(9)) bus ();

  wr_ctrl #(.MAX_BURST(MB), .BURST_W(16), .USEDW_W(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  beat_t       exp_beats[$];
  logic [31:0] exp_done[$];
  logic [31:0] fifo[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beats_seen = 0;
  int dones_seen = 0;
  int first_write_cyc = -1;
  int last_done_cyc = -1;
  bit pop_pend = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void sync_fifo();
    bus.empty  = (fifo.size() == 0);
    bus.usedw  = 9'(fifo.size());
    bus.fifo_q = (fifo.size() != 0) ? fifo[0] : 32'hDEAD_BEEF;
  endfunction

  function automatic void load_fifo(input logic [31:0] d0, input int n);
    for (int i = 0; i < n; i++) fifo.push_back(d0 + 32'(i));
    sync_fifo();
  endfunction

  // Expected beats for a run of nw words from base, split into MB-word bursts
  function automatic void exp_region(input logic [31:0] base, input int nw, input logic [31:0] d0);
    for (int w = 0; w < nw; w++) begin
      beat_t x;
      int bi;
      int bl;
      bi = w / MB;
      bl = ((nw - bi * MB) < MB) ? (nw - bi * MB) : MB;
      x.addr = (base & ~32'd3) + 32'(bi * 16);
      x.bc   = 16'(bl);
      x.data = d0 + 32'(w);
      exp_beats.push_back(x);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model pops one word per beat accepted at the preceding edge
  always @(posedge clk) begin
    #1;
    if (pop_pend) begin
      void'(fifo.pop_front());
      pop_pend = 1'b0;
    end
    sync_fifo();
  end

  // Monitor: every presented beat must match the scoreboard head; accepted beats retire it
  always @(negedge clk) begin
    beat_t e;
    if (!reset) begin
      if (bus.write) begin
        if (first_write_cyc < 0) first_write_cyc = cyc;
        if (exp_beats.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", bus.address, bus.writedata);
        end else begin
          e = exp_beats[0];
          check("beat_addr", bus.address, e.addr);
          check("beat_burstcount", 32'(bus.burstcount), 32'(e.bc));
          check("beat_data", bus.writedata, e.data);
          check("beat_rdreq", 32'(bus.rdreq), 32'(!bus.waitrequest));
          if (!bus.waitrequest) begin
            void'(exp_beats.pop_front());
            pop_pend = 1'b1;
            beats_seen++;
          end
        end
      end
      if (bus.wr_done) begin
        dones_seen++;
        last_done_cyc = cyc;
        if (exp_done.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got wr_done=1 expected 0");
        end else begin
          check("done_words_written", bus.words_written, exp_done.pop_front());
        end
      end
    end
  end

  task automatic start_run(input logic [31:0] b, input logic [31:0] e, output int n);
    @(posedge clk); #1;
    bus.buf_begin   = b;
    bus.buf_end     = e;
    bus.wr_ctrl     = 1'b1;
    first_write_cyc = -1;
    @(posedge clk); #1;
    bus.wr_ctrl = 1'b0;
    n = cyc;
    check("rdy_after_start", 32'(bus.wr_ctrl_rdy), 32'd0);
  endtask

  task automatic wait_done(input string name);
    int start;
    int k;
    start = dones_seen;
    k = 0;
    while (dones_seen == start && k < 200) begin
      @(posedge clk);
      k++;
    end
    check({name, "_done_seen"}, 32'(dones_seen != start), 32'd1);
    @(posedge clk); #1;
    check({name, "_rdy_idle"}, 32'(bus.wr_ctrl_rdy), 32'd1);
    check({name, "_beats_left"}, 32'(exp_beats.size()), 32'd0);
  endtask

  task automatic wait_beats(input int target);
    int k;
    k = 0;
    while (beats_seen < target && k < 100) begin
      @(posedge clk);
      k++;
    end
    check("beat_wait", 32'(beats_seen >= target), 32'd1);
  endtask

  initial begin
    int n;
    int p;
    int b0;
    bus.wr_ctrl     = 1'b0;
    bus.flush       = 1'b0;
    bus.buf_begin   = '0;
    bus.buf_end     = '0;
    bus.waitrequest = 1'b0;
    sync_fifo();

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_rdy", 32'(bus.wr_ctrl_rdy), 32'd1);
    check("rst_done", 32'(bus.wr_done), 32'd0);
    check("rst_write", 32'(bus.write), 32'd0);
    check("rst_address", bus.address, 32'd0);
    check("rst_burstcount", 32'(bus.burstcount), 32'd0);
    check("rst_words", bus.words_written, 32'd0);
    check("rst_rdreq", 32'(bus.rdreq), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic: 8 words in two bursts of 4, write visible two edges after start
    load_fifo(32'd10, 8);
    exp_region(32'h0, 8, 32'd10);
    exp_done.push_back(32'd8);
    start_run(32'h0, 32'h20, n);
    wait_done("basic");
    check("basic_latency", 32'(first_write_cyc), 32'(n + 1));
    check("basic_words", bus.words_written, 32'd8);

    // Remainder: 6 words -> 4 + 2; ragged end address gives the same result
    load_fifo(32'd20, 6);
    exp_region(32'h0, 6, 32'd20);
    exp_done.push_back(32'd6);
    start_run(32'h0, 32'h18, n);
    wait_done("rem18");
    load_fifo(32'd30, 6);
    exp_region(32'h0, 6, 32'd30);
    exp_done.push_back(32'd6);
    start_run(32'h0, 32'h1B, n);
    wait_done("rem1b");

    // Stall: waitrequest held for 3 cycles while beat 2 is presented
    load_fifo(32'd10, 8);
    exp_region(32'h100, 8, 32'd10);
    exp_done.push_back(32'd8);
    b0 = beats_seen;
    start_run(32'h100, 32'h120, n);
    wait_beats(b0 + 1);
    #1 bus.waitrequest = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.waitrequest = 1'b0;
    wait_done("stall");
    check("stall_beats", 32'(beats_seen - b0), 32'd8);

    // Underfill: 2 of 4 words present, no write until the rest arrive
    load_fifo(32'd40, 2);
    exp_region(32'h200, 4, 32'd40);
    exp_done.push_back(32'd4);
    start_run(32'h200, 32'h210, n);
    repeat (10) @(posedge clk);
    #1;
    check("underfill_no_write", 32'(first_write_cyc), 32'hFFFF_FFFF);
    check("underfill_write_low", 32'(bus.write), 32'd0);
    load_fifo(32'd42, 2);
    p = cyc;
    wait_done("underfill");
    check("underfill_start", 32'((first_write_cyc - p) <= 2 && first_write_cyc > p), 32'd1);

    // Empty and inverted regions complete with no write, wr_done two edges after start
    exp_done.push_back(32'd0);
    start_run(32'h300, 32'h300, n);
    wait_done("empty");
    check("empty_done_latency", 32'(last_done_cyc), 32'(n + 1));
    check("empty_no_write", 32'(first_write_cyc), 32'hFFFF_FFFF);
    exp_done.push_back(32'd0);
    start_run(32'h400, 32'h300, n);
    wait_done("inverted");
    check("inverted_no_write", 32'(first_write_cyc), 32'hFFFF_FFFF);

    // Flush during the first of four bursts: that burst finishes, then done
    load_fifo(32'd50, 16);
    exp_region(32'h500, 4, 32'd50);
    exp_done.push_back(32'd4);
    start_run(32'h500, 32'h540, n);
    p = 0;
    while (first_write_cyc < 0 && p < 50) begin
      @(posedge clk);
      p++;
    end
    #1 bus.flush = 1'b1;
    wait_done("flush");
    check("flush_words", bus.words_written, 32'd4);
    bus.flush = 1'b0;
    fifo.delete();
    sync_fifo();

    // Unaligned begin: low address bits dropped, 4 words from 0x600
    load_fifo(32'd70, 4);
    exp_region(32'h602, 4, 32'd70);
    exp_done.push_back(32'd4);
    start_run(32'h602, 32'h612, n);
    wait_done("unaligned");

    // Reset after beat 1 drops write at once; next run restarts from buf_begin
    load_fifo(32'd10, 8);
    exp_region(32'h0, 8, 32'd10);
    b0 = beats_seen;
    start_run(32'h0, 32'h20, n);
    wait_beats(b0 + 1);
    #1 reset = 1'b1;
    #1;
    check("midrst_write", 32'(bus.write), 32'd0);
    check("midrst_rdy", 32'(bus.wr_ctrl_rdy), 32'd1);
    check("midrst_words", bus.words_written, 32'd0);
    exp_beats.delete();
    @(posedge clk); #2;
    fifo.delete();
    sync_fifo();
    @(posedge clk); #1;
    reset = 1'b0;
    load_fifo(32'd10, 8);
    exp_region(32'h0, 8, 32'd10);
    exp_done.push_back(32'd8);
    start_run(32'h0, 32'h20, n);
    wait_done("after_rst");
    check("after_rst_words", bus.words_written, 32'd8);
    check("done_queue_empty", 32'(exp_done.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
